// File: rtl/tt_vpu_ovi_pkg.sv
// Shared definitions for the OVI vector store drain.
// Holds the parameter defaults and the drain FSM state encoding.
// No ports: this is a package imported by tt_vpu_ovi_st_fifo and
// tt_vpu_ovi_store_drain.
package tt_vpu_ovi_pkg;

  localparam int DEF_VLEN    = 256;
  localparam int DEF_STORE_W = 512;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_CREDITS = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FILL   = 2'd1;
  localparam state_t ST_SYNC   = 2'd2;
  localparam state_t ST_LQWAIT = 2'd3;

endpackage

// File: rtl/tt_vpu_ovi_st_fifo.sv
// Store data buffer: DEPTH entries of VLEN bits with single-entry push and
// multi-entry pop (0..RATIO entries per cycle).
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clear         synchronous flush of pointers and occupancy
//   push          write push_data at the tail
//   push_data     VLEN-bit entry
//   pop_cnt       number of entries retired from the head this cycle
//   head_data     the RATIO oldest entries, head entry in the low lane
//   occupancy     number of valid entries
//   full, empty   occupancy flags
module tt_vpu_ovi_st_fifo
  import tt_vpu_ovi_pkg::*;
#(
  parameter int VLEN  = DEF_VLEN,
  parameter int DEPTH = DEF_DEPTH,
  parameter int RATIO = DEF_STORE_W / DEF_VLEN
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic [VLEN-1:0]         push_data,
  input  logic [$clog2(RATIO):0]  pop_cnt,
  output logic [RATIO*VLEN-1:0]   head_data,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [VLEN-1:0] mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [OW-1:0]   occ_r;

  // Entry storage; contents need no reset because occupancy gates every use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; a same-cycle push
  // and pop moves occupancy by push - pop_cnt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r <= rd_ptr_r + PW'(pop_cnt);
      occ_r    <= occ_r + OW'(push) - OW'(pop_cnt);
    end
  end

  for (genvar i = 0; i < RATIO; i++) begin : g_head
    assign head_data[i*VLEN +: VLEN] = mem_r[rd_ptr_r + PW'(i)];
  end

  assign occupancy = occ_r;
  assign full      = (occ_r == OW'(DEPTH));
  assign empty     = (occ_r == '0);

endmodule

// File: rtl/tt_vpu_ovi_store_drain.sv
// OVI vector store drain: buffers vs3 register data, packs RATIO registers
// into each OVI store beat under credit flow control, runs the memop sync
// handshake and signals completion once the load/store queue has drained.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin a store (ignored while busy)
//   wr_valid/ready/data   vs3 register write into the buffer
//   lq_done               final register of the store is being presented
//   lq_empty              load/store queue empty
//   abort                 synchronous kill of the current store
//   store_valid/data      OVI store beat (entry 0 in the low lane)
//   store_credit          one OVI store credit returned
//   memop_sync_start/end  sync handshake
//   commit                one-cycle completion pulse
//   busy                  store in progress
//   err_overflow          sticky: write while full or credit beyond CREDITS
module tt_vpu_ovi_store_drain
  import tt_vpu_ovi_pkg::*;
#(
  parameter int VLEN    = DEF_VLEN,
  parameter int STORE_W = DEF_STORE_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CREDITS = DEF_CREDITS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [VLEN-1:0]    wr_data,
  input  logic               lq_done,
  input  logic               lq_empty,
  input  logic               abort,
  output logic               store_valid,
  output logic [STORE_W-1:0] store_data,
  input  logic               store_credit,
  output logic               memop_sync_start,
  input  logic               memop_sync_end,
  output logic               commit,
  output logic               busy,
  output logic               err_overflow
);

  localparam int RATIO = STORE_W / VLEN;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int CW    = $clog2(RATIO) + 1;
  localparam int CRW   = $clog2(CREDITS) + 1;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               done_r;
  logic               sync_end_r;
  logic [CRW-1:0]     credits_r;
  logic               store_valid_r;
  logic [STORE_W-1:0] store_data_r;
  logic               sync_start_r;
  logic               commit_r;
  logic               err_r;

  logic               accepting_s;
  logic               wr_fire_s;
  logic               done_set_s;
  logic               issue_s;
  logic [CW-1:0]      pop_cnt_s;
  logic [STORE_W-1:0] head_s;
  logic [STORE_W-1:0] beat_s;
  logic [OW-1:0]      occ_s;
  logic               full_s;
  logic               empty_s;
  logic               credit_full_s;

  // The start cycle itself may carry the first register.
  assign accepting_s   = (state_r == ST_FILL) || ((state_r == ST_IDLE) && start);
  assign wr_ready      = !full_s && ((state_r == ST_IDLE) || (state_r == ST_FILL));
  assign wr_fire_s     = wr_valid && wr_ready && accepting_s && !abort;
  // lq_done only counts once its accompanying register (if any) is taken.
  assign done_set_s    = accepting_s && lq_done && (!wr_valid || wr_fire_s) && !abort;
  assign credit_full_s = (credits_r == CRW'(CREDITS));

  tt_vpu_ovi_st_fifo #(
    .VLEN  (VLEN),
    .DEPTH (DEPTH),
    .RATIO (RATIO)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (abort),
    .push      (wr_fire_s),
    .push_data (wr_data),
    .pop_cnt   (pop_cnt_s),
    .head_data (head_s),
    .occupancy (occ_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Beat issue: a full beat when RATIO entries wait, otherwise a partial
  // flush of the tail once the final register has been seen.
  always_comb begin
    issue_s   = 1'b0;
    pop_cnt_s = '0;
    if (abort || (state_r != ST_FILL) || (credits_r == '0)) begin
      issue_s = 1'b0;
    end else if (occ_s >= OW'(RATIO)) begin
      issue_s   = 1'b1;
      pop_cnt_s = CW'(RATIO);
    end else if (done_r && !empty_s) begin
      issue_s   = 1'b1;
      pop_cnt_s = CW'(occ_s);
    end else begin
      issue_s = 1'b0;
    end
  end

  // Zero the lanes a partial beat does not fill.
  always_comb begin
    beat_s = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CW'(i) < pop_cnt_s) begin
        beat_s[i*VLEN +: VLEN] = head_s[i*VLEN +: VLEN];
      end else begin
        beat_s[i*VLEN +: VLEN] = '0;
      end
    end
  end

  // Next-state logic; FILL waits for the last beat to leave before syncing.
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = start ? ST_FILL : ST_IDLE;
        ST_FILL:   state_nxt_s = (done_r && empty_s && !store_valid_r && !wr_fire_s)
                                 ? ST_SYNC : ST_FILL;
        ST_SYNC:   state_nxt_s = (memop_sync_end || sync_end_r) ? ST_LQWAIT : ST_SYNC;
        ST_LQWAIT: state_nxt_s = lq_empty ? ST_IDLE : ST_LQWAIT;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM state plus the done and early-sync_end flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      done_r     <= 1'b0;
      sync_end_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (abort) begin
        done_r <= 1'b0;
      end else if (done_set_s) begin
        done_r <= 1'b1;
      end else if (state_r != ST_FILL) begin
        done_r <= 1'b0;
      end else begin
        done_r <= done_r;
      end
      // A sync_end that beats the drain is held until SYNC consumes it.
      if (abort) begin
        sync_end_r <= 1'b0;
      end else if ((state_r == ST_FILL) && memop_sync_end) begin
        sync_end_r <= 1'b1;
      end else if (state_r == ST_SYNC) begin
        sync_end_r <= 1'b0;
      end else begin
        sync_end_r <= sync_end_r;
      end
    end
  end

  // Credit pool and sticky overflow; credits survive an abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits_r <= CRW'(CREDITS);
      err_r     <= 1'b0;
    end else begin
      if (issue_s && !store_credit) begin
        credits_r <= credits_r - CRW'(1);
      end else if (!issue_s && store_credit && !credit_full_s) begin
        credits_r <= credits_r + CRW'(1);
      end else begin
        credits_r <= credits_r;
      end
      err_r <= err_r
             | (store_credit && !issue_s && credit_full_s)
             | (wr_valid && full_s && accepting_s);
    end
  end

  // Registered beat and handshake pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      store_valid_r <= 1'b0;
      store_data_r  <= '0;
      sync_start_r  <= 1'b0;
      commit_r      <= 1'b0;
    end else begin
      store_valid_r <= issue_s;
      store_data_r  <= issue_s ? beat_s : '0;
      sync_start_r  <= (state_r == ST_IDLE) && start && !abort;
      commit_r      <= (state_r == ST_LQWAIT) && lq_empty && !abort;
    end
  end

  assign store_valid      = store_valid_r;
  assign store_data       = store_data_r;
  assign memop_sync_start = sync_start_r;
  assign commit           = commit_r;
  assign busy             = (state_r != ST_IDLE);
  assign err_overflow     = err_r;

endmodule

// File: tb/tb_tt_vpu_ovi_store_drain.sv
module tb_tt_vpu_ovi_store_drain;

  localparam int VLEN    = 256;
  localparam int STORE_W = 512;
  localparam int DEPTH   = 8;
  localparam int CREDITS = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               wr_valid = 1'b0;
  logic               wr_ready;
  logic [VLEN-1:0]    wr_data = '0;
  logic               lq_done = 1'b0;
  logic               lq_empty = 1'b0;
  logic               abort = 1'b0;
  logic               store_valid;
  logic [STORE_W-1:0] store_data;
  logic               store_credit = 1'b0;
  logic               memop_sync_start;
  logic               memop_sync_end = 1'b0;
  logic               commit;
  logic               busy;
  logic               err_overflow;

  always #5 clk = ~clk;

  tt_vpu_ovi_store_drain #(
    .VLEN(VLEN), .STORE_W(STORE_W), .DEPTH(DEPTH), .CREDITS(CREDITS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .lq_done(lq_done),
    .lq_empty(lq_empty), .abort(abort), .store_valid(store_valid),
    .store_data(store_data), .store_credit(store_credit),
    .memop_sync_start(memop_sync_start), .memop_sync_end(memop_sync_end),
    .commit(commit), .busy(busy), .err_overflow(err_overflow)
  );

  int errors = 0;
  int checks = 0;
  int beats = 0;
  int syncs = 0;
  int commits = 0;
  bit mon_en = 1'b0;
  bit auto_credit = 1'b0;
  logic [STORE_W-1:0] exp_q[$];

  typedef struct {
    int st, wv, di, ld, le, ab, cr, se;
    int busy, rdy, sv, lo, hi, ss, cm, er;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [VLEN-1:0] mkd(input int k);
    logic [VLEN-1:0] d;
    if (k == 0) d = '0;
    else d = {8{32'hA500_0000 | 32'(k)}};
    return d;
  endfunction

  function automatic logic [STORE_W-1:0] mkb(input int lo, input int hi);
    return {mkd(hi), mkd(lo)};
  endfunction

  task automatic check_vec(input string name, input logic [STORE_W-1:0] act,
                           input logic [STORE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // One clock: outputs are sampled 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
    if (store_valid) begin
      beats++;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got %0h, expected no beat", store_data);
        end else begin
          check_vec("beat_data", store_data, exp_q.pop_front());
        end
      end
    end
    if (memop_sync_start) syncs++;
    if (commit) commits++;
    store_credit = auto_credit && store_valid;
  endtask

  task automatic wr(input int k, input bit last);
    check_bit($sformatf("wr_ready_%0d", k), wr_ready, 1'b1);
    wr_valid = 1'b1;
    wr_data  = mkd(k);
    lq_done  = last;
    cyc();
    wr_valid = 1'b0;
    lq_done  = 1'b0;
  endtask

  task automatic wait_commit(input int budget);
    int c0;
    c0 = commits;
    for (int i = 0; i < budget; i++) begin
      if (commits != c0) break;
      cyc();
    end
  endtask

  initial begin
    //            st wv di ld le ab cr se | busy rdy sv lo hi ss cm er
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{1, 1, 2, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 3, 1, 0, 0, 0, 0,   1, 1, 1, 1, 2, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 3, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0};

    // Reset values while reset is held.
    #12;
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_wr_ready", wr_ready, 1'b1);
    check_bit("rst_store_valid", store_valid, 1'b0);
    check_vec("rst_store_data", store_data, '0);
    check_bit("rst_sync_start", memop_sync_start, 1'b0);
    check_bit("rst_commit", commit, 1'b0);
    check_bit("rst_err", err_overflow, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table: 3 writes -> full beat + partial beat, manual credits, sync, commit.
    for (int i = 0; i < 11; i++) begin
      start          = (tbl[i].st != 0);
      wr_valid       = (tbl[i].wv != 0);
      wr_data        = mkd(tbl[i].di);
      lq_done        = (tbl[i].ld != 0);
      lq_empty       = (tbl[i].le != 0);
      abort          = (tbl[i].ab != 0);
      store_credit   = (tbl[i].cr != 0);
      memop_sync_end = (tbl[i].se != 0);
      cyc();
      check_bit($sformatf("v%0d_busy", i), busy, tbl[i].busy != 0);
      check_bit($sformatf("v%0d_wr_ready", i), wr_ready, tbl[i].rdy != 0);
      check_bit($sformatf("v%0d_store_valid", i), store_valid, tbl[i].sv != 0);
      if (tbl[i].sv != 0)
        check_vec($sformatf("v%0d_store_data", i), store_data, mkb(tbl[i].lo, tbl[i].hi));
      check_bit($sformatf("v%0d_sync_start", i), memop_sync_start, tbl[i].ss != 0);
      check_bit($sformatf("v%0d_commit", i), commit, tbl[i].cm != 0);
      check_bit($sformatf("v%0d_err", i), err_overflow, tbl[i].er != 0);
    end

    // 8 writes, credits returned per beat, sync_end latched during FILL.
    mon_en = 1'b1; auto_credit = 1'b1;
    beats = 0; syncs = 0; commits = 0; lq_empty = 1'b0;
    for (int k = 1; k <= 4; k++) exp_q.push_back(mkb(10 + 2*k - 1, 10 + 2*k));
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) memop_sync_end = 1'b1;
      wr(10 + k, k == 8);
      start = 1'b0;
      memop_sync_end = 1'b0;
    end
    for (int i = 0; i < 30; i++) cyc();
    check_int("b8_beats", beats, 4);
    check_int("b8_sync_pulses", syncs, 1);
    check_int("b8_commit_before_lq_empty", commits, 0);
    check_bit("b8_busy_in_lqwait", busy, 1'b1);
    check_int("b8_queue_left", exp_q.size(), 0);
    lq_empty = 1'b1;
    wait_commit(10);
    check_int("b8_commits", commits, 1);
    check_bit("b8_idle", busy, 1'b0);
    lq_empty = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    check_int("b8_single_commit", commits, 1);

    // Credit starvation: 2 credits, 8 writes -> 2 beats, 1 return -> 1 more.
    auto_credit = 1'b0; store_credit = 1'b0;
    beats = 0; commits = 0;
    for (int k = 1; k <= 4; k++) exp_q.push_back(mkb(50 + 2*k - 1, 50 + 2*k));
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wr(50 + k, k == 8);
      start = 1'b0;
    end
    for (int i = 0; i < 20; i++) cyc();
    check_int("cr_stall_beats", beats, 2);
    store_credit = 1'b1;
    cyc();
    store_credit = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    check_int("cr_one_return_beats", beats, 3);
    auto_credit = 1'b1;
    store_credit = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) cyc();
    check_int("cr_all_beats", beats, 4);
    check_int("cr_queue_left", exp_q.size(), 0);
    store_credit = 1'b1;
    memop_sync_end = 1'b1;
    cyc();
    memop_sync_end = 1'b0;
    lq_empty = 1'b1;
    wait_commit(10);
    check_int("cr_commits", commits, 1);
    lq_empty = 1'b0;
    cyc();

    // Abort after 3 writes; next store must start from an empty buffer.
    beats = 0; commits = 0;
    exp_q.push_back(mkb(61, 62));
    start = 1'b1;
    wr(61, 1'b0);
    start = 1'b0;
    wr(62, 1'b0);
    wr(63, 1'b0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check_bit("ab_idle", busy, 1'b0);
    check_bit("ab_wr_ready", wr_ready, 1'b1);
    for (int i = 0; i < 5; i++) cyc();
    check_int("ab_no_commit", commits, 0);
    check_int("ab_beats", beats, 1);
    exp_q.push_back(mkb(71, 72));
    start = 1'b1;
    wr(71, 1'b0);
    start = 1'b0;
    memop_sync_end = 1'b1;
    wr(72, 1'b1);
    memop_sync_end = 1'b0;
    lq_empty = 1'b1;
    wait_commit(20);
    check_int("ab_next_beats", beats, 2);
    check_int("ab_next_commit", commits, 1);
    check_int("ab_queue_left", exp_q.size(), 0);
    lq_empty = 1'b0;
    for (int i = 0; i < 3; i++) cyc();

    // Credit returned with the pool already full -> sticky overflow.
    auto_credit = 1'b0;
    check_bit("ovf_clear", err_overflow, 1'b0);
    store_credit = 1'b1;
    cyc();
    store_credit = 1'b0;
    check_bit("ovf_set", err_overflow, 1'b1);
    cyc();
    check_bit("ovf_sticky", err_overflow, 1'b1);

    // Asynchronous reset in the middle of FILL with a beat on the bus.
    exp_q.push_back(mkb(81, 82));
    start = 1'b1;
    wr(81, 1'b0);
    start = 1'b0;
    wr(82, 1'b0);
    wr(83, 1'b0);
    check_bit("mid_store_valid", store_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check_bit("arst_busy", busy, 1'b0);
    check_bit("arst_wr_ready", wr_ready, 1'b1);
    check_bit("arst_store_valid", store_valid, 1'b0);
    check_vec("arst_store_data", store_data, '0);
    check_bit("arst_sync_start", memop_sync_start, 1'b0);
    check_bit("arst_commit", commit, 1'b0);
    check_bit("arst_err", err_overflow, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
